// File: rtl/chroma_interp_pipe.sv
// Pipelined H.264 chroma bilinear interpolator with valid/ready streaming and per-block sequencing.
// Optional macro CHROMA_RAW_OUT_EN adds out_raw, the unrounded weighted sum aligned with out_pix.
module chroma_interp_pipe #(
   parameter int BIT_DEPTH = 8,
   parameter int FRAC_BITS = 3,
   parameter int CNT_W     = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [FRAC_BITS-1:0] xfrac,
   input  logic [FRAC_BITS-1:0] yfrac,
   input  logic [CNT_W-1:0]     num_samples,
   output logic                 busy,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_DEPTH-1:0] a,
   input  logic [BIT_DEPTH-1:0] b,
   input  logic [BIT_DEPTH-1:0] c,
   input  logic [BIT_DEPTH-1:0] d,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_DEPTH-1:0] out_pix,
   output logic                 out_last
`ifdef CHROMA_RAW_OUT_EN
   ,
   output logic [BIT_DEPTH+2*FRAC_BITS-1:0] out_raw
`endif
);

   localparam int PW = BIT_DEPTH + 2 * FRAC_BITS;
   localparam int WW = 2 * FRAC_BITS + 1;
   localparam int FW = FRAC_BITS + 1;
   localparam logic [FW-1:0] W_FULL = FW'(1) << FRAC_BITS;
   localparam logic [PW-1:0] RND    = PW'(1) << (2 * FRAC_BITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [FRAC_BITS-1:0] xfrac_q, yfrac_q;
   logic [CNT_W-1:0]     num_q, in_count;

   logic [FW-1:0] wx0, wx1, wy0, wy1;
   logic [WW-1:0] w00, w10, w01, w11;
   logic          adv, accept, in_last, done;

   logic          s1_v, s1_last, s2_v, s2_last;
   logic [PW-1:0] s1_pa, s1_pb, s1_pc, s1_pd, s2_sum;

   // Weights carry one extra bit so W - 0 = W is represented exactly.
   assign wx1 = {1'b0, xfrac_q};
   assign wy1 = {1'b0, yfrac_q};
   assign wx0 = W_FULL - wx1;
   assign wy0 = W_FULL - wy1;
   assign w00 = WW'(wx0) * WW'(wy0);
   assign w10 = WW'(wx1) * WW'(wy0);
   assign w01 = WW'(wx0) * WW'(wy1);
   assign w11 = WW'(wx1) * WW'(wy1);

   assign adv      = !out_valid || out_ready;
   assign in_ready = (state_q == RUN) && adv;
   assign accept   = in_valid && in_ready;
   assign in_last  = (in_count == num_q - CNT_W'(1));
   assign done     = out_valid && out_ready && out_last;
   assign busy     = (state_q != IDLE);

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)            state_d = RUN;
         RUN:     if (accept && in_last) state_d = DRAIN;
         DRAIN:   if (done)             state_d = IDLE;
         default:                       state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         xfrac_q  <= '0;
         yfrac_q  <= '0;
         num_q    <= '0;
         in_count <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            xfrac_q  <= xfrac;
            yfrac_q  <= yfrac;
            num_q    <= (num_samples == '0) ? CNT_W'(1) : num_samples;
            in_count <= '0;
         end else if (accept) begin
            in_count <= in_count + CNT_W'(1);
         end
      end
   end

   // Products and sums cannot overflow PW bits because the four weights total W^2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_last   <= 1'b0;
         s1_pa     <= '0;
         s1_pb     <= '0;
         s1_pc     <= '0;
         s1_pd     <= '0;
         s2_v      <= 1'b0;
         s2_last   <= 1'b0;
         s2_sum    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_pix   <= '0;
`ifdef CHROMA_RAW_OUT_EN
         out_raw   <= '0;
`endif
      end else if (adv) begin
         s1_v      <= accept;
         s1_last   <= accept && in_last;
         s1_pa     <= PW'(w00) * PW'(a);
         s1_pb     <= PW'(w10) * PW'(b);
         s1_pc     <= PW'(w01) * PW'(c);
         s1_pd     <= PW'(w11) * PW'(d);
         s2_v      <= s1_v;
         s2_last   <= s1_last;
         s2_sum    <= s1_pa + s1_pb + s1_pc + s1_pd;
         out_valid <= s2_v;
         out_last  <= s2_last;
         out_pix   <= BIT_DEPTH'((s2_sum + RND) >> (2 * FRAC_BITS));
`ifdef CHROMA_RAW_OUT_EN
         out_raw   <= s2_sum;
`endif
      end
   end

endmodule

// File: doc/chroma_interp_pipe.md
Name: chroma_interp_pipe

Overview:
Pipelined, parametrised H.264 chroma bilinear interpolator. It computes ((8-x)(8-y)A + x(8-y)B + (8-x)yC + xyD + 32) >> 6, generalised to FRAC_BITS precision, with rounding, a valid/ready stream interface and per-block sequencing. It sits between the reference-pixel fetch and the MC prediction buffer, and processes one block's sample quads under a single latched (xfrac, yfrac).

Parameters:
BIT_DEPTH, 8, sample width of A/B/C/D and of the result.
FRAC_BITS, 3, fractional position bits; weight total W = 2^FRAC_BITS.
CNT_W, 9, width of the per-block sample count (supports up to 2^CNT_W-1 samples).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  block start pulse; accepted only in IDLE
xfrac  in  FRAC_BITS  horizontal fraction, latched on accepted start
yfrac  in  FRAC_BITS  vertical fraction, latched on accepted start
num_samples  in  CNT_W  samples in block, latched on accepted start; 0 is treated as 1
busy  out  1  high in RUN and DRAIN
in_valid  in  1  quad A/B/C/D valid
in_ready  out  1  quad accepted when in_valid && in_ready
a, b, c, d  in  BIT_DEPTH each  top-left, top-right, bottom-left, bottom-right samples
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_pix  out  BIT_DEPTH  interpolated sample
out_last  out  1  high with the final result of the block

Behaviour:
- Reset: all outputs 0. State IDLE. Stage valids cleared. Latched frac and count are 0.
- FSM:
  - IDLE: start -> RUN. Latch fracs and num_samples, and clear the input counter.
  - RUN: in_count increments per accepted quad. On acceptance of quad num_samples -> DRAIN.
  - DRAIN: stays until the result carrying out_last is accepted (out_valid && out_ready), then -> IDLE.
  - start is ignored outside IDLE.
- Pipeline: 3 stages with global enable adv = !out_valid || out_ready.
  - S1: register wx0 = W-xfrac, wx1 = xfrac, wy0 = W-yfrac, wy1 = yfrac. Register the four products, each BIT_DEPTH+2*FRAC_BITS bits wide. The weight subtraction uses FRAC_BITS+1 bits, so W is exact. No truncation of weights is allowed.
  - S2: the sum is BIT_DEPTH+2*FRAC_BITS bits and cannot overflow, because the weights total W^2.
  - S3: out_pix = (sum + 2^(2*FRAC_BITS-1)) >> (2*FRAC_BITS). This always fits in BIT_DEPTH, so no clip is needed.
- Latency: 3 cycles from acceptance to out_valid with out_ready held high. Throughput is 1 quad per cycle.
- in_ready = (state==RUN) && adv. It is 0 in IDLE and DRAIN.
- Stall: while out_valid && !out_ready, out_pix, out_last and all stage registers hold, and no bubble is lost. in_valid dropping mid-block inserts bubbles (stage valid = 0), and out_valid is gated by them.
- out_last travels with the quad that made in_count == num_samples.
- Back-to-back blocks: the next start is only accepted once in IDLE, so the pipeline is empty at each block start.
- Mid-operation reset: immediate return to the reset state. Partial results are discarded.

Optional Feature:
Macro CHROMA_RAW_OUT_EN.
- Defined: extra output port out_raw (BIT_DEPTH+2*FRAC_BITS) carries the unrounded S2 sum, aligned with out_pix and held under stall.
- Undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Integer position: start with x=0, y=0, n=1; quad a=200, b=c=d=0 -> out_pix=200 and out_last=1, 3 cycles after acceptance; then busy falls.
- Centre: x=4, y=4, n=1; a=10, b=20, c=30, d=41 -> sum 1616, out_pix=25 (with the macro, out_raw=1616).
- Maximum: x=7, y=7, a=b=c=d=255 -> out_pix=255, with no overflow in the raw sum (16320).
- Backpressure: n=4, four consecutive quads; out_ready low for 3 cycles at the 2nd result -> the 4 results arrive in order and unchanged, in_ready drops during the stall, and out_last is set only on the 4th.
- Protocol: start pulsed in RUN with x=1 -> ignored, and the fracs stay as latched. n=0 -> exactly one quad accepted and out_last set on it.
- Reset: rst_n asserted with 2 results in flight -> out_valid=0 and busy=0 immediately; a new start after release yields correct results.
